// File: rtl/jtag_tap_datapath.sv
// jtag_tap_datapath: IR, BYPASS, IDCODE and USER data registers driven by TAP state strobes, with TDO launch.
module jtag_tap_datapath #(
   parameter int IR_W = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
   parameter int USER_W = 16,
   parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(4'h1),
   parameter logic [IR_W-1:0] OP_USER = IR_W'(4'h2),
   parameter logic [IR_W-1:0] OP_BYPASS = '1
) (
   input  logic              TCK,
   input  logic              TRST,
   input  logic              TDI,
   input  logic              tap_reset,
   input  logic              ir_capture,
   input  logic              ir_shift,
   input  logic              ir_update,
   input  logic              dr_capture,
   input  logic              dr_shift,
   input  logic              dr_update,
   input  logic [USER_W-1:0] user_din,
   output logic              TDO,
   output logic              tdo_en,
   output logic [IR_W-1:0]   instr,
   output logic [USER_W-1:0] user_dout,
   output logic              user_update
);
   logic [IR_W-1:0] ir_q, ir_d, instr_q, instr_d;
   logic byp_q, byp_d;
   logic [31:0] id_q, id_d;
   logic [USER_W-1:0] usr_q, usr_d, dout_q, dout_d;
   logic upd_q, upd_d, tdo_q, tdo_en_q;
   logic busy, cap_ir, cap_dr, sh_ir, sh_dr, up_ir, up_dr;
   logic sel_id, sel_usr, sel_byp, dr_bit;
   // Resolve simultaneous strobes: tap_reset > capture > shift > update.
   assign busy    = tap_reset | ir_capture | dr_capture;
   assign cap_ir  = !tap_reset & ir_capture;
   assign cap_dr  = !tap_reset & !ir_capture & dr_capture;
   assign sh_ir   = !busy & ir_shift;
   assign sh_dr   = !busy & !ir_shift & dr_shift;
   assign up_ir   = !busy & !ir_shift & !dr_shift & ir_update;
   assign up_dr   = !busy & !ir_shift & !dr_shift & !ir_update & dr_update;
   assign sel_id  = instr_q == OP_IDCODE;
   assign sel_usr = instr_q == OP_USER;
   assign sel_byp = (instr_q == OP_BYPASS) | !(sel_id | sel_usr);
   assign dr_bit  = sel_id ? id_q[0] : sel_usr ? usr_q[0] : byp_q;
   // Next-state for IR, instruction and the selected data register.
   always_comb begin
      ir_d    = tap_reset ? '0 : cap_ir ? IR_W'(2'b01) : sh_ir ? {TDI, ir_q[IR_W-1:1]} : ir_q;
      instr_d = tap_reset ? OP_IDCODE : up_ir ? ir_q : instr_q;
      byp_d   = tap_reset ? 1'b0 : (cap_dr & sel_byp) ? 1'b0 : (sh_dr & sel_byp) ? TDI : byp_q;
      id_d    = tap_reset ? '0 : (cap_dr & sel_id) ? IDCODE_VAL : (sh_dr & sel_id) ? {TDI, id_q[31:1]} : id_q;
      usr_d   = tap_reset ? '0 : (cap_dr & sel_usr) ? user_din : (sh_dr & sel_usr) ? {TDI, usr_q[USER_W-1:1]} : usr_q;
      upd_d   = up_dr & sel_usr;
      dout_d  = (up_dr & sel_usr) ? usr_q : dout_q;
   end
   // Rising-edge state; TRST clears everything, including the parallel USER output.
   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         ir_q    <= '0;
         instr_q <= OP_IDCODE;
         byp_q   <= 1'b0;
         id_q    <= '0;
         usr_q   <= '0;
         dout_q  <= '0;
         upd_q   <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         instr_q <= instr_d;
         byp_q   <= byp_d;
         id_q    <= id_d;
         usr_q   <= usr_d;
         dout_q  <= dout_d;
         upd_q   <= upd_d;
      end
   end
   // TDO launches on the falling edge so it is stable across the next rising edge.
   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= sh_ir ? ir_q[0] : sh_dr ? dr_bit : 1'b0;
         tdo_en_q <= sh_ir | sh_dr;
      end
   end
   assign TDO         = tdo_q;
   assign tdo_en      = tdo_en_q;
   assign instr       = instr_q;
   assign user_dout   = dout_q;
   assign user_update = upd_q;
endmodule

// File: tb/tb_jtag_tap_datapath.sv
// tb_jtag_tap_datapath: randomized scan scenarios checked against a queue-based register model.
module tb_jtag_tap_datapath;
   logic TCK = 0, TRST = 0, TDI = 0, tap_reset = 0;
   logic ir_capture = 0, ir_shift = 0, ir_update = 0, dr_capture = 0, dr_shift = 0, dr_update = 0;
   logic [15:0] user_din = 0;
   logic TDO, tdo_en, user_update;
   logic [3:0] instr;
   logic [15:0] user_dout;
   int total = 0, bad = 0;
   logic so, se;
   logic [15:0] m_dout = 0;
   localparam logic [31:0] IDC = 32'h1234_5679;
   localparam logic [6:0] IDLE = 7'b0000000, TRS = 7'b1000000, CAP_IR = 7'b0100000, SH_IR = 7'b0010000,
                          UP_IR = 7'b0001000, CAP_DR = 7'b0000100, SH_DR = 7'b0000010, UP_DR = 7'b0000001;

   jtag_tap_datapath dut (
      .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_reset(tap_reset),
      .ir_capture(ir_capture), .ir_shift(ir_shift), .ir_update(ir_update),
      .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
      .user_din(user_din), .TDO(TDO), .tdo_en(tdo_en), .instr(instr),
      .user_dout(user_dout), .user_update(user_update)
   );

   always #5 TCK = ~TCK;

   task automatic step(input logic [6:0] s, input logic t);
      {tap_reset, ir_capture, ir_shift, ir_update, dr_capture, dr_shift, dr_update} = s;
      TDI = t;
      @(negedge TCK);
      #1 so = TDO;
      se = tdo_en;
      @(posedge TCK);
      #1;
   endtask

   task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
      step(CAP_IR, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(SH_IR, v[i]);
         o[i] = so;
      end
      step(UP_IR, 1'b0);
   endtask

   task automatic scan_dr(input logic [63:0] t, input int n, input bit upd,
                          output logic [63:0] o, output logic [63:0] e, output logic ce);
      o = '0;
      e = '0;
      step(CAP_DR, 1'b0);
      ce = se;
      for (int i = 0; i < n; i++) begin
         step(SH_DR, t[i]);
         o[i] = so;
         e[i] = se;
      end
      if (upd) step(UP_DR, 1'b0);
   endtask

   // Selected DR is a FIFO of its captured bits: each shift pops the front to TDO and appends TDI.
   task automatic model(input logic [3:0] ins, input logic [15:0] din, input logic [63:0] t, input int n,
                        output logic [63:0] o, output logic [15:0] ra);
      logic q[$];
      logic [31:0] cap;
      int len;
      cap = ins == 4'h1 ? IDC : ins == 4'h2 ? {16'h0, din} : 32'h0;
      len = ins == 4'h1 ? 32 : ins == 4'h2 ? 16 : 1;
      o = '0;
      ra = '0;
      for (int i = 0; i < len; i++) q.push_back(cap[i]);
      for (int i = 0; i < n; i++) begin
         o[i] = q.pop_front();
         q.push_back(t[i]);
      end
      for (int i = 0; i < len && i < 16; i++) ra[i] = q[i];
   endtask

   task automatic test_reset();
      TRST = 1;
      #2 TRST = 0;
      #1;
      total++; if (instr !== 4'h1) begin bad++; $display("FAIL reset_instr got=%h exp=1", instr); end
      total++; if ({TDO, tdo_en, user_update} !== 3'b000) begin bad++; $display("FAIL reset_outs got=%b exp=000", {TDO, tdo_en, user_update}); end
      total++; if (user_dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", user_dout); end
      @(negedge TCK);
      TRST = 1;
      @(posedge TCK);
      #1;
   endtask

   task automatic test_idcode();
      logic [63:0] o, e;
      logic ce;
      scan_dr(64'h0, 32, 0, o, e, ce);
      total++; if (o[31:0] !== IDC) begin bad++; $display("FAIL idcode_out got=%h exp=%h", o[31:0], IDC); end
      total++; if (e[31:0] !== 32'hFFFF_FFFF || ce !== 1'b0) begin bad++; $display("FAIL idcode_en got=%h/%b exp=ffffffff/0", e[31:0], ce); end
      step(IDLE, 1'b0);
      total++; if (se !== 1'b0) begin bad++; $display("FAIL idcode_en_idle got=%b exp=0", se); end
      total++; if (instr !== 4'h1) begin bad++; $display("FAIL idcode_instr got=%h exp=1", instr); end
   endtask

   task automatic test_ir_bypass();
      logic [3:0] o4;
      logic [63:0] o, e;
      logic ce;
      scan_ir(4'hF, o4);
      total++; if (o4 !== 4'b0001) begin bad++; $display("FAIL ir_capture_out got=%b exp=0001", o4); end
      total++; if (instr !== 4'hF) begin bad++; $display("FAIL ir_instr got=%h exp=f", instr); end
      scan_dr(64'b101, 3, 0, o, e, ce);
      total++; if (o[2:0] !== 3'b010) begin bad++; $display("FAIL bypass_out got=%b exp=010", o[2:0]); end
   endtask

   task automatic test_user();
      logic [3:0] o4;
      logic [63:0] o, e, eo;
      logic [15:0] ra;
      logic ce;
      user_din = 16'h0F0F;
      scan_ir(4'h2, o4);
      model(4'h2, user_din, 64'hA5C3, 16, eo, ra);
      scan_dr(64'hA5C3, 16, 1, o, e, ce);
      m_dout = ra;
      total++; if (o[15:0] !== eo[15:0]) begin bad++; $display("FAIL user_out got=%h exp=%h", o[15:0], eo[15:0]); end
      total++; if (user_dout !== m_dout) begin bad++; $display("FAIL user_dout got=%h exp=%h", user_dout, m_dout); end
      total++; if (user_update !== 1'b1) begin bad++; $display("FAIL user_pulse got=%b exp=1", user_update); end
      step(IDLE, 1'b0);
      total++; if (user_update !== 1'b0) begin bad++; $display("FAIL user_pulse_end got=%b exp=0", user_update); end
   endtask

   task automatic test_tap_reset();
      logic [63:0] o, e;
      logic ce;
      step(TRS, 1'b0);
      total++; if (instr !== 4'h1) begin bad++; $display("FAIL tapreset_instr got=%h exp=1", instr); end
      total++; if (user_dout !== m_dout) begin bad++; $display("FAIL tapreset_dout got=%h exp=%h", user_dout, m_dout); end
      total++; if (se !== 1'b0 || user_update !== 1'b0) begin bad++; $display("FAIL tapreset_outs got=%b%b exp=00", se, user_update); end
      scan_dr(64'h0, 32, 0, o, e, ce);
      total++; if (o[31:0] !== IDC) begin bad++; $display("FAIL tapreset_idcode got=%h exp=%h", o[31:0], IDC); end
   endtask

   task automatic test_undefined();
      logic [3:0] o4;
      logic [63:0] t, o, e, eo;
      logic [15:0] ra;
      logic ce;
      scan_ir(4'h7, o4);
      t = {$urandom, $urandom};
      model(4'h7, user_din, t, 20, eo, ra);
      scan_dr(t, 20, 1, o, e, ce);
      total++; if (o[19:0] !== eo[19:0]) begin bad++; $display("FAIL undef_bypass got=%h exp=%h", o[19:0], eo[19:0]); end
      total++; if (user_dout !== m_dout || user_update !== 1'b0) begin bad++; $display("FAIL undef_update got=%h/%b exp=%h/0", user_dout, user_update, m_dout); end
   endtask

   task automatic test_random();
      logic [3:0] ins, o4;
      logic [63:0] t, o, e, eo, mask;
      logic [15:0] ra;
      logic ce, u;
      int n, len;
      for (int k = 0; k < 12; k++) begin
         ins = k % 4 == 0 ? 4'h1 : k % 4 == 1 ? 4'h2 : k % 4 == 2 ? 4'hF : 4'($urandom);
         len = ins == 4'h1 ? 32 : ins == 4'h2 ? 16 : 1;
         n = $urandom_range(1, len + 8);
         t = {$urandom, $urandom};
         u = 1'($urandom_range(0, 1));
         user_din = 16'($urandom);
         scan_ir(ins, o4);
         total++; if (instr !== ins) begin bad++; $display("FAIL rand_instr k=%0d got=%h exp=%h", k, instr, ins); end
         model(ins, user_din, t, n, eo, ra);
         scan_dr(t, n, u, o, e, ce);
         mask = (64'd1 << n) - 64'd1;
         total++; if ((o & mask) !== (eo & mask)) begin bad++; $display("FAIL rand_out k=%0d ins=%h n=%0d got=%h exp=%h", k, ins, n, o & mask, eo & mask); end
         total++; if ((e & mask) !== mask) begin bad++; $display("FAIL rand_en k=%0d got=%h exp=%h", k, e & mask, mask); end
         if (u) begin
            if (ins == 4'h2) m_dout = ra;
            total++; if (user_update !== (ins == 4'h2)) begin bad++; $display("FAIL rand_pulse k=%0d got=%b exp=%b", k, user_update, ins == 4'h2); end
         end
         total++; if (user_dout !== m_dout) begin bad++; $display("FAIL rand_dout k=%0d got=%h exp=%h", k, user_dout, m_dout); end
      end
   endtask

   task automatic test_trst_mid();
      logic [3:0] o4;
      scan_ir(4'h2, o4);
      user_din = 16'hFFFF;
      step(CAP_DR, 1'b0);
      for (int i = 0; i < 8; i++) step(SH_DR, 1'($urandom));
      #2 TRST = 0;
      m_dout = 16'h0;
      #1;
      total++; if (instr !== 4'h1) begin bad++; $display("FAIL trst_instr got=%h exp=1", instr); end
      total++; if ({TDO, tdo_en} !== 2'b00) begin bad++; $display("FAIL trst_tdo got=%b exp=00", {TDO, tdo_en}); end
      total++; if (user_dout !== m_dout || user_update !== 1'b0) begin bad++; $display("FAIL trst_dout got=%h/%b exp=0/0", user_dout, user_update); end
      @(negedge TCK);
      TRST = 1;
      @(posedge TCK);
      #1;
      step(UP_DR, 1'b0);
      total++; if (user_update !== 1'b0 || user_dout !== m_dout) begin bad++; $display("FAIL trst_noupdate got=%h/%b exp=0/0", user_dout, user_update); end
   endtask

   initial begin
      test_reset();
      test_idcode();
      test_ir_bypass();
      test_user();
      test_tap_reset();
      test_undefined();
      test_random();
      test_trst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jtag_tap_datapath.md
Name: jtag_tap_datapath

Overview:
- Instruction/data-register datapath directly downstream of the TAP controller FSM.
- Consumes the controller's decoded state strobes (capture/shift/update for IR and DR, test reset).
- Holds the instruction register, BYPASS, IDCODE and one USER data register, and drives TDO.
- The USER register gives the SoC a parallel read/write window that is scanned over JTAG.

Parameters:
- IR_W, 4, instruction register width (>=2).
- IDCODE_VAL, 32'h1234_5679, IDCODE DR contents; bit 0 must be 1.
- USER_W, 16, USER DR width (>=1).
- OP_IDCODE, 4'h1, IDCODE opcode.
- OP_USER, 4'h2, USER opcode.
- OP_BYPASS, all ones, BYPASS opcode.

Ports:
- TCK  in  1  TAP clock, the only clock; logic uses rising edge, TDO launches on falling edge.
- TRST  in  1  reset; asynchronous, active-low.
- TDI  in  1  serial data in.
- tap_reset  in  1  high while the TAP is in Test-Logic-Reset.
- ir_capture, ir_shift, ir_update  in  1 each  TAP state decodes for the IR path.
- dr_capture, dr_shift, dr_update  in  1 each  TAP state decodes for the DR path.
- user_din  in  USER_W  parallel capture value for USER.
- TDO  out  1  serial data out.
- tdo_en  out  1  TDO output enable.
- instr  out  IR_W  active instruction.
- user_dout  out  USER_W  last USER value written over JTAG.
- user_update  out  1  one-cycle pulse when user_dout is written.

Behaviour:
- Reset:
  - TRST low, asynchronous: instr=OP_IDCODE; IR shift reg=0; all DR shift regs=0; user_dout=0; user_update=0; TDO=0; tdo_en=0.
  - tap_reset high, synchronous (rising edge): same values, except user_dout is held.
  - TRST asserted mid-scan aborts the scan; no update occurs.
- Strobes are levels. Each takes effect on the rising TCK edge while asserted, i.e. the edge leaving that TAP state.
  - At most one strobe is high per cycle. If several are high, priority is tap_reset > capture > shift > update.
- IR path:
  - ir_capture: IR shift reg <= {0..., 2'b01}.
  - ir_shift: shift right, TDI enters the MSB; bit 0 is the serial output.
  - ir_update: instr <= IR shift reg.
  - Shifting does not change instr.
- DR selection by instr: OP_IDCODE -> IDCODE; OP_USER -> USER; every other value, including OP_BYPASS -> BYPASS.
- BYPASS DR:
  - dr_capture loads 0.
  - dr_shift loads TDI (1-bit delay).
- IDCODE DR (32 bits):
  - dr_capture loads IDCODE_VAL.
  - dr_shift shifts right, TDI into the MSB.
  - dr_update has no effect.
- USER DR (USER_W bits):
  - dr_capture loads user_din.
  - dr_shift shifts right, TDI into the MSB.
  - dr_update with USER selected: user_dout <= shift reg; user_update=1 for exactly the next TCK cycle.
  - dr_update is ignored when USER is not selected.
- Only the selected DR captures and shifts; unselected DRs hold their value.
- TDO timing:
  - On the falling TCK edge: TDO <= IR bit 0 if ir_shift, else selected-DR bit 0 if dr_shift, else 0.
  - tdo_en <= ir_shift | dr_shift on the same falling edge.
  - The first shifted-out bit is therefore the captured bit 0, valid half a cycle after entering Shift.
- Long scans (more bits than the register length) keep shifting; TDI bits appear at TDO after register-length cycles.
- instr changes only on ir_update, TRST or tap_reset.

Test Plan:
- TRST pulse, then capture + 32 dr_shift cycles with TDI=0 -> TDO yields 0x12345679 LSB first; tdo_en high only during the shifts; instr=0x1.
- IR capture + 4 ir_shift cycles with TDI=1, then ir_update -> TDO yields 1,0,0,0; instr=0xF.
  - Then a DR scan shifting 1,0,1 -> TDO yields 0 (captured),1,0.
- IR=0x2, DR capture with user_din=0x0F0F, shift 16 bits with TDI=0xA5C3 LSB first, then dr_update:
  - TDO yields 0x0F0F.
  - user_dout=0xA5C3.
  - user_update high exactly one cycle.
- IR=0x7 (undefined) -> behaves as BYPASS with a 1-cycle TDI->TDO delay; dr_update leaves user_dout unchanged.
- TRST low mid USER shift (8 of 16 bits) -> instr=0x1, TDO=0, tdo_en=0, user_dout=0, no user_update pulse.
- tap_reset high for 1 cycle after user_dout=0xA5C3 -> instr=0x1, user_dout stays 0xA5C3.
